// File: rtl/spart_bus_arb_if.sv
// Client-side handshake bundle for spart_bus_arb: two request ports plus the
// shared completion/read-data/error return path.
interface spart_bus_arb_if;
  logic       req0;
  logic       req1;
  logic       we0;
  logic       we1;
  logic [1:0] addr0;
  logic [1:0] addr1;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic       done0;
  logic       done1;
  logic [7:0] rdata;
  logic       err;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output done0, done1, rdata, err
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  done0, done1, rdata, err
  );
endinterface

// File: rtl/spart_bus_arb.sv
// SPART I/O bus sequencer: writes the baud divisor after reset, then serves two
// clients round-robin, holding buffer accesses until tbr/rda report ready.
module spart_bus_arb #(
  parameter int TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       cfg_done,
  spart_bus_arb_if.slave bus
);

  typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, WAIT, ACCESS, DONE} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  function automatic logic [15:0] divisor(input logic [1:0] sel);
    case (sel)
      2'b00:   return 16'h0516;
      2'b01:   return 16'h028B;
      2'b10:   return 16'h0146;
      default: return 16'h00A3;
    endcase
  endfunction

  state_t      r_state, w_next;
  logic [1:0]  r_br;
  logic        r_gnt, r_last, r_we, r_to;
  logic [1:0]  r_addr;
  logic [7:0]  r_wdata;
  logic [15:0] r_cnt;
  logic        r_iocs, r_iorw;
  logic [1:0]  r_ioaddr;
  logic [7:0]  r_dout;
  logic        r_done0, r_done1, r_err, r_cfg_done;
  logic [7:0]  r_rdata;

  logic        w_iocs, w_iorw;
  logic [1:0]  w_ioaddr;
  logic [7:0]  w_dout;
  logic        w_grant, w_gnt, w_ready, w_timeout;
  logic [1:0]  w_div_sel;
  logic [15:0] w_div;

  // The low byte goes out while br_cfg is being latched; the high byte uses the latched copy.
  assign w_div_sel = (r_state == CFG_LO) ? br_cfg : r_br;
  assign w_div     = divisor(w_div_sel);
  assign w_ready   = (r_addr != 2'b00) || (r_we ? tbr : rda);

  always_ff @(posedge clk) begin
    if (rst) r_state <= CFG_LO;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_iocs    = 1'b0;
    w_iorw    = 1'b1;
    w_ioaddr  = r_ioaddr;
    w_dout    = r_dout;
    w_grant   = bus.req0 | bus.req1;
    w_gnt     = (bus.req0 & bus.req1) ? ~r_last : bus.req1;
    w_timeout = (TIMEOUT != 0) && !w_ready && (r_cnt == TO_LAST);
    case (r_state)
      CFG_LO: begin
        w_next   = CFG_HI;
        w_iocs   = 1'b1;
        w_iorw   = 1'b0;
        w_ioaddr = 2'b10;
        w_dout   = w_div[7:0];
      end
      CFG_HI: begin
        w_next   = IDLE;
        w_iocs   = 1'b1;
        w_iorw   = 1'b0;
        w_ioaddr = 2'b11;
        w_dout   = w_div[15:8];
      end
      IDLE:    if (w_grant) w_next = WAIT;
      WAIT: begin
        if (w_ready)        w_next = ACCESS;
        else if (w_timeout) w_next = DONE;
      end
      ACCESS: begin
        w_next   = DONE;
        w_iocs   = 1'b1;
        w_iorw   = ~r_we;
        w_ioaddr = r_addr;
        w_dout   = r_wdata;
      end
      DONE:    w_next = IDLE;
      default: w_next = CFG_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_iocs     <= 1'b0;
      r_iorw     <= 1'b1;
      r_ioaddr   <= 2'b00;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= 8'h00;
      r_cfg_done <= 1'b0;
      r_last     <= 1'b1;
      r_cnt      <= 16'h0000;
      r_to       <= 1'b0;
    end else begin
      r_iocs   <= w_iocs;
      r_iorw   <= w_iorw;
      r_ioaddr <= w_ioaddr;
      r_done0  <= (r_state == DONE) && !r_gnt;
      r_done1  <= (r_state == DONE) && r_gnt;
      r_err    <= (r_state == DONE) && r_to;
      if (r_state != CFG_LO && r_state != CFG_HI) r_cfg_done <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_gnt   <= w_gnt;
            r_we    <= w_gnt ? bus.we1    : bus.we0;
            r_addr  <= w_gnt ? bus.addr1  : bus.addr0;
            r_wdata <= w_gnt ? bus.wdata1 : bus.wdata0;
            r_cnt   <= 16'h0000;
            r_to    <= 1'b0;
          end
        end
        WAIT: begin
          if (!w_ready) begin
            if (w_timeout) r_to  <= 1'b1;
            else           r_cnt <= r_cnt + 16'd1;
          end
        end
        // The ACCESS strobe is on the bus during this cycle, so the SPART is still driving read data.
        DONE: begin
          r_last <= r_gnt;
          if (!r_we && !r_to) r_rdata <= databus;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    r_dout <= w_dout;
    if (r_state == CFG_LO) r_br <= br_cfg;
  end

  assign iocs      = r_iocs;
  assign iorw      = r_iorw;
  assign ioaddr    = r_ioaddr;
  assign cfg_done  = r_cfg_done;
  assign databus   = (r_iocs && !r_iorw) ? r_dout : 8'hzz;
  assign bus.done0 = r_done0;
  assign bus.done1 = r_done1;
  assign bus.rdata = r_rdata;
  assign bus.err   = r_err;

endmodule

// File: tb/tb_spart_bus_arb.sv
// Scoreboard bench for spart_bus_arb: stimulus queues expected bus cycles and
// completions from a transaction-level model; a monitor pops and compares them.
module tb_spart_bus_arb;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] br_cfg = 2'b00;
  logic       rda = 1'b0;
  logic       tbr = 1'b0;
  wire        iocs, iorw, cfg_done;
  wire  [1:0] ioaddr;
  wire  [7:0] databus;

  logic [7:0] rx_byte = 8'h00;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] hold = 8'h00;
  logic       last_served = 1'b1;

  typedef struct {
    logic       rw;
    logic [1:0] addr;
    logic [7:0] data;
  } bus_t;

  typedef struct {
    int         client;
    logic       err;
    logic [7:0] rdata;
    int         cyc;
  } done_t;

  bus_t  exp_bus[$];
  done_t exp_done[$];
  bus_t  mb;
  done_t md;

  spart_bus_arb_if bus();

  spart_bus_arb #(.TIMEOUT(N)) dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .rda(rda), .tbr(tbr),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
    .cfg_done(cfg_done), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SPART model: returns the RX byte at address 0 and a fixed pattern elsewhere.
  assign databus = (iocs && iorw) ? ((ioaddr == 2'b00) ? rx_byte : {6'h2C, ioaddr}) : 8'hzz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (iocs) begin
        if (exp_bus.size() == 0) chk("bus_unexpected_iocs", {31'b0, iocs}, 32'd0);
        else begin
          mb = exp_bus.pop_front();
          chk("bus_iorw", {31'b0, iorw}, {31'b0, mb.rw});
          chk("bus_addr", {30'b0, ioaddr}, {30'b0, mb.addr});
          if (!mb.rw) chk("bus_wdata", {24'b0, databus}, {24'b0, mb.data});
        end
      end
      if (bus.done0 || bus.done1) begin
        if (exp_done.size() == 0) chk("done_unexpected", {30'b0, bus.done1, bus.done0}, 32'd0);
        else begin
          md = exp_done.pop_front();
          chk("done_client", bus.done1 ? 32'd1 : 32'd0, md.client);
          chk("done_both", {31'b0, bus.done0 & bus.done1}, 32'd0);
          chk("done_err", {31'b0, bus.err}, {31'b0, md.err});
          chk("done_rdata", {24'b0, bus.rdata}, {24'b0, md.rdata});
          chk("done_cycle", cyc, md.cyc);
        end
      end
    end
  end

  task automatic set_client(input int c, input bit we, input bit [1:0] a, input bit [7:0] wd, input bit req);
    if (c == 0) begin
      bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd; bus.req0 = req;
    end else begin
      bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd; bus.req1 = req;
    end
  endtask

  task automatic do_reset(input bit [1:0] cfg, input bit change);
    logic [15:0] div;
    bus_t        b;
    rst = 1'b1; bus.req0 = 1'b0; bus.req1 = 1'b0; tbr = 1'b0; rda = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {16'h0, iocs, iorw, ioaddr, bus.done0, bus.done1, bus.err, bus.rdata, cfg_done},
        32'h0000_4000);
    exp_bus.delete();
    exp_done.delete();
    hold = 8'h00;
    last_served = 1'b1;
    case (cfg)
      2'b00:   div = 16'h0516;
      2'b01:   div = 16'h028B;
      2'b10:   div = 16'h0146;
      default: div = 16'h00A3;
    endcase
    b.rw = 1'b0; b.addr = 2'b10; b.data = div[7:0];  exp_bus.push_back(b);
    b.rw = 1'b0; b.addr = 2'b11; b.data = div[15:8]; exp_bus.push_back(b);
    br_cfg = cfg;
    rst = 1'b0;
    @(negedge clk);
    chk("cfg_c1_iocs", {31'b0, iocs}, 32'd1);
    chk("cfg_c1_done", {31'b0, cfg_done}, 32'd0);
    if (change) br_cfg = ~cfg;
    @(negedge clk);
    chk("cfg_c2_iocs", {31'b0, iocs}, 32'd1);
    chk("cfg_c2_done", {31'b0, cfg_done}, 32'd0);
    @(negedge clk);
    chk("cfg_c3_iocs", {31'b0, iocs}, 32'd0);
    chk("cfg_c3_done", {31'b0, cfg_done}, 32'd1);
  endtask

  // d = number of WAIT cycles the buffer target reports not-ready.
  task automatic do_access(input int c, input bit we, input bit [1:0] a, input bit [7:0] wd,
                           input int d, input bit [7:0] rx);
    int    eff_d;
    bit    e, seen;
    done_t dx;
    bus_t  bx;
    rx_byte = rx;
    e     = (a == 2'b00) && (d >= N);
    eff_d = (a == 2'b00) ? d : 0;
    tbr   = (a == 2'b00 && !we);
    rda   = (a == 2'b00 && we);
    if (!we && !e) hold = (a == 2'b00) ? rx : {6'h2C, a};
    dx.client = c; dx.err = e; dx.rdata = hold;
    dx.cyc = cyc + 1 + (e ? N + 1 : eff_d + 3);
    exp_done.push_back(dx);
    if (!e) begin
      bx.rw = !we; bx.addr = a; bx.data = wd;
      exp_bus.push_back(bx);
    end
    last_served = c[0];
    set_client(c, we, a, wd, 1'b1);
    seen = 1'b0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge clk);
      if (k == eff_d + 1 && a == 2'b00) begin
        if (we) tbr = 1'b1;
        else    rda = 1'b1;
      end
      if (bus.done0 || bus.done1) seen = 1'b1;
    end
    chk("done_seen", {31'b0, seen}, 32'd1);
    set_client(c, we, a, wd, 1'b0);
  endtask

  task automatic do_round_robin();
    bit         rwe[2][3];
    bit [1:0]   raddr[2][3];
    bit [7:0]   rwd[2][3];
    int         p[2];
    int         idx[2];
    int         c, c0;
    logic       ls;
    done_t      dx;
    bus_t       bx;
    rx_byte = 8'($urandom);
    tbr = 1'b1;
    rda = 1'b1;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 3; j++) begin
        rwe[i][j]   = 1'($urandom);
        raddr[i][j] = 2'($urandom);
        rwd[i][j]   = 8'($urandom);
      end
    p[0] = 0; p[1] = 0; ls = last_served; c0 = cyc;
    for (int k = 0; k < 6; k++) begin
      if (p[0] < 3 && p[1] < 3) c = ls ? 0 : 1;
      else                      c = (p[0] < 3) ? 0 : 1;
      if (!rwe[c][p[c]]) hold = (raddr[c][p[c]] == 2'b00) ? rx_byte : {6'h2C, raddr[c][p[c]]};
      dx.client = c; dx.err = 1'b0; dx.rdata = hold; dx.cyc = c0 + 4 + 4 * k;
      exp_done.push_back(dx);
      bx.rw = !rwe[c][p[c]]; bx.addr = raddr[c][p[c]]; bx.data = rwd[c][p[c]];
      exp_bus.push_back(bx);
      ls = c[0];
      p[c]++;
    end
    last_served = ls;
    idx[0] = 0; idx[1] = 0;
    set_client(0, rwe[0][0], raddr[0][0], rwd[0][0], 1'b1);
    set_client(1, rwe[1][0], raddr[1][0], rwd[1][0], 1'b1);
    for (int k = 0; k < 80 && (idx[0] + idx[1]) < 6; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if ((i == 0) ? bus.done0 : bus.done1) begin
          idx[i]++;
          if (idx[i] < 3) set_client(i, rwe[i][idx[i]], raddr[i][idx[i]], rwd[i][idx[i]], 1'b1);
          else            set_client(i, 1'b0, 2'b00, 8'h00, 1'b0);
        end
      end
    end
    chk("rr_complete", idx[0] + idx[1], 32'd6);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int         cl, dd;
    bit         we;
    bit [1:0]   a;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = 2'b00; bus.addr1 = 2'b00; bus.wdata0 = 8'h00; bus.wdata1 = 8'h00;

    do_reset(2'b01, 1'b0);
    do_reset(2'b00, 1'b0);
    do_reset(2'b10, 1'b1);
    do_reset(2'b11, 1'b0);

    do_access(0, 1'b1, 2'b00, 8'h41, 5, 8'h00);
    do_access(1, 1'b0, 2'b00, 8'h00, 0, 8'h5A);
    do_access(0, 1'b1, 2'b00, 8'h33, 100, 8'h00);
    do_access(1, 1'b1, 2'b00, 8'h55, N - 1, 8'h00);
    do_access(1, 1'b0, 2'b00, 8'h00, N, 8'hC3);
    do_access(0, 1'b0, 2'b01, 8'h00, 0, 8'h00);

    for (int t = 0; t < 30; t++) begin
      cl = $urandom_range(0, 1);
      we = 1'($urandom);
      a  = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom_range(1, 3));
      dd = $urandom_range(0, 11);
      do_access(cl, we, a, 8'($urandom), dd, 8'($urandom));
    end

    do_reset(2'b01, 1'b0);
    do_round_robin();
    repeat (2) @(negedge clk);
    do_round_robin();

    set_client(0, 1'b1, 2'b00, 8'h77, 1'b1);
    tbr = 1'b0;
    rda = 1'b1;
    repeat (3) @(negedge clk);
    do_reset(2'b11, 1'b0);
    repeat (12) @(negedge clk);

    chk("exp_bus_empty", exp_bus.size(), 32'd0);
    chk("exp_done_empty", exp_done.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
